// File: rtl/video_pkg.sv
// video_pkg: shared timing-mode constants and sync polarity encodings
package video_pkg;
    // Level driven on a sync output while it is asserted
    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;
    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
    localparam int VGA640_H_VISIBLE = 640;
    localparam int VGA640_H_FP      = 16;
    localparam int VGA640_H_SYNC    = 96;
    localparam int VGA640_H_BP      = 48;
    localparam int VGA640_V_VISIBLE = 480;
    localparam int VGA640_V_FP      = 10;
    localparam int VGA640_V_SYNC    = 2;
    localparam int VGA640_V_BP      = 33;
    localparam logic VGA640_HS_POL  = POL_ACTIVE_LOW;
    localparam logic VGA640_VS_POL  = POL_ACTIVE_LOW;
    // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs
    localparam int SVGA800_H_VISIBLE = 800;
    localparam int SVGA800_H_FP      = 40;
    localparam int SVGA800_H_SYNC    = 128;
    localparam int SVGA800_H_BP      = 88;
    localparam int SVGA800_V_VISIBLE = 600;
    localparam int SVGA800_V_FP      = 1;
    localparam int SVGA800_V_SYNC    = 4;
    localparam int SVGA800_V_BP      = 23;
    localparam logic SVGA800_HS_POL  = POL_ACTIVE_HIGH;
    localparam logic SVGA800_VS_POL  = POL_ACTIVE_HIGH;
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: fixed-depth register pipeline with async reset to a chosen idle value
module sync_delay_line #(
    parameter int DEPTH = 2,
    parameter int W = 1,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk_pix,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    if (DEPTH == 0) begin : g_wire
        assign dout = din;
    end else begin : g_pipe
        logic [W-1:0] stage [DEPTH];
        // Shift one stage per clock; reset parks every stage at its idle value
        always_ff @(posedge clk_pix or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= INIT;
            end else begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end
        assign dout = stage[DEPTH-1];
    end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters with registered coordinates, syncs, blanking and frame strobes
module video_timing_gen
    import video_pkg::*;
#(
    parameter int   H_VISIBLE = VGA640_H_VISIBLE,
    parameter int   H_FP      = VGA640_H_FP,
    parameter int   H_SYNC    = VGA640_H_SYNC,
    parameter int   H_BP      = VGA640_H_BP,
    parameter int   V_VISIBLE = VGA640_V_VISIBLE,
    parameter int   V_FP      = VGA640_V_FP,
    parameter int   V_SYNC    = VGA640_V_SYNC,
    parameter int   V_BP      = VGA640_V_BP,
    parameter logic HS_POL    = POL_ACTIVE_LOW,
    parameter logic VS_POL    = POL_ACTIVE_LOW,
    parameter int   CW        = 12,
    parameter int   PIPE_DLY  = 2
) (
    input  logic          clk_pix,
    input  logic          reset,
    input  logic          restart,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          display_en,
    output logic          line_tick,
    output logic          frame_tick,
    output logic          vblank_tick,
    output logic [15:0]   frame_count
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
    localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FP + V_SYNC);

    // Elaboration-time guard: the counters must be able to reach the last line/pixel
    if (((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_cw_check
        $fatal(1, "video_timing_gen: CW=%0d too narrow for %0dx%0d totals", CW, H_TOTAL, V_TOTAL);
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_dly_check
        $fatal(1, "video_timing_gen: PIPE_DLY=%0d outside 0..15", PIPE_DLY);
    end

    logic [CW-1:0] h_cnt, v_cnt;
    logic h_wrap, f_wrap, vis, hs_r, vs_r, de_r;

    assign h_wrap = (h_cnt == H_LAST);
    assign f_wrap = h_wrap && (v_cnt == V_LAST);
    assign vis    = (h_cnt < H_VIS) && (v_cnt < V_VIS);

    // Raster position; restart snaps straight back to the frame origin
    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset || restart) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
    end

    // Output register stage: every externally visible signal is decoded here, one clock after the counters
    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            active      <= 1'b0;
            de_r        <= 1'b0;
            hs_r        <= ~HS_POL;
            vs_r        <= ~VS_POL;
            line_tick   <= 1'b0;
            frame_tick  <= 1'b0;
            vblank_tick <= 1'b0;
        end else begin
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            active      <= vis;
            de_r        <= vis;
            hs_r        <= (h_cnt >= HS_START && h_cnt < HS_END) ? HS_POL : ~HS_POL;
            vs_r        <= (v_cnt >= VS_START && v_cnt < VS_END) ? VS_POL : ~VS_POL;
            line_tick   <= h_wrap;
            frame_tick  <= f_wrap;
            vblank_tick <= (h_cnt == H_VIS - 1'b1) && (v_cnt == V_VIS - 1'b1);
        end
    end

    // Completed-frame counter; a restart landing on the wrap cycle abandons that frame
    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) frame_count <= '0;
        else if (f_wrap && !restart) frame_count <= frame_count + 1'b1;
    end

    sync_delay_line #(
        .DEPTH(PIPE_DLY),
        .W(3),
        .INIT({~HS_POL, ~VS_POL, 1'b0})
    ) u_dly (
        .clk_pix(clk_pix),
        .reset(reset),
        .din({hs_r, vs_r, de_r}),
        .dout({hsync, vsync, display_en})
    );
endmodule
